// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcode fetch/decode/execute step sequencer
// Drives the datapath register strobes and bus enables from (step, opcode, flags).
module control_sequencer #(
   parameter int OpcodeBits = 4,
   parameter bit EarlyEnd   = 1'b1
) (
   input  logic                  clock,
   input  logic                  bReset,
   input  logic                  step_en,
   input  logic [OpcodeBits-1:0] opcode,
   input  logic                  carry_flag,
   input  logic                  zero_flag,
   output logic                  pc_inc,
   output logic                  pc_load,
   output logic                  pc_out,
   output logic                  mar_we,
   output logic                  ram_we,
   output logic                  ram_out,
   output logic                  ir_we,
   output logic                  ir_out,
   output logic                  a_we,
   output logic                  a_out,
   output logic                  b_we,
   output logic                  alu_out,
   output logic                  alu_sub,
   output logic                  flags_we,
   output logic                  out_we,
   output logic                  halted,
   output logic [2:0]            step
);

   typedef enum logic [2:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4
   } step_t;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_STA = 4'h4;
   localparam logic [3:0] OP_LDI = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_JZ  = 4'h8;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   step_t      step_q;
   step_t      seq_next;
   step_t      last_step;
   logic       halted_q;
   logic       step_valid;
   logic       active;
   logic [3:0] op;

   assign op         = opcode[3:0];
   assign step_valid = (step_q <= T4);
   assign active     = bReset && step_en && !halted_q && step_valid;
   assign step       = step_q;
   assign halted     = halted_q;

   always_comb begin
      case (step_q)
         T0:      seq_next = T1;
         T1:      seq_next = T2;
         T2:      seq_next = T3;
         T3:      seq_next = T4;
         default: seq_next = T0;
      endcase
   end

   // Last active step per opcode; anything not listed finishes after T2.
   always_comb begin
      case (op)
         OP_LDA, OP_STA: last_step = T3;
         OP_ADD, OP_SUB: last_step = T4;
         default:        last_step = T2;
      endcase
   end

   always_ff @(posedge clock or negedge bReset) begin
      if (!bReset) begin
         step_q   <= T0;
         halted_q <= 1'b0;
      end else if (!step_valid) begin
         step_q <= T0;
      end else if (step_en && !halted_q) begin
         if (step_q == T2 && op == OP_HLT) begin
            halted_q <= 1'b1;
         end else if (EarlyEnd && step_q == last_step) begin
            step_q <= T0;
         end else begin
            step_q <= seq_next;
         end
      end
   end

   always_comb begin
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      pc_out   = 1'b0;
      mar_we   = 1'b0;
      ram_we   = 1'b0;
      ram_out  = 1'b0;
      ir_we    = 1'b0;
      ir_out   = 1'b0;
      a_we     = 1'b0;
      a_out    = 1'b0;
      b_we     = 1'b0;
      alu_out  = 1'b0;
      alu_sub  = 1'b0;
      flags_we = 1'b0;
      out_we   = 1'b0;
      if (active) begin
         case (step_q)
            T0: begin
               pc_out = 1'b1;
               mar_we = 1'b1;
            end
            T1: begin
               ram_out = 1'b1;
               ir_we   = 1'b1;
               pc_inc  = 1'b1;
            end
            T2: begin
               case (op)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     ir_out = 1'b1;
                     mar_we = 1'b1;
                  end
                  OP_LDI: begin
                     ir_out = 1'b1;
                     a_we   = 1'b1;
                  end
                  OP_JMP: begin
                     ir_out  = 1'b1;
                     pc_load = 1'b1;
                  end
                  // Flags come straight from the flags register, so a T4 update is already visible here.
                  OP_JC: begin
                     ir_out  = carry_flag;
                     pc_load = carry_flag;
                  end
                  OP_JZ: begin
                     ir_out  = zero_flag;
                     pc_load = zero_flag;
                  end
                  OP_OUT: begin
                     a_out  = 1'b1;
                     out_we = 1'b1;
                  end
                  default: ;
               endcase
            end
            T3: begin
               case (op)
                  OP_LDA: begin
                     ram_out = 1'b1;
                     a_we    = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     ram_out = 1'b1;
                     b_we    = 1'b1;
                  end
                  OP_STA: begin
                     a_out  = 1'b1;
                     ram_we = 1'b1;
                  end
                  default: ;
               endcase
            end
            T4: begin
               if (op == OP_ADD || op == OP_SUB) begin
                  alu_out  = 1'b1;
                  a_we     = 1'b1;
                  flags_we = 1'b1;
                  alu_sub  = (op == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
